// File: rtl/fft_sample_mem_responder_if.sv
// Avalon-MM pipelined-read bus between an FFT wrapper master and the sample memory responder.
interface fft_sample_mem_responder_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/fft_sample_mem_responder.sv
// On-chip SDRAM stand-in: 2**ADDR_W word buffer with fixed-latency pipelined reads and back-pressure.
// Define STALL_INJECT_EN to add LFSR-driven pseudo-random waitrequest stalls.
module fft_sample_mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int RD_LATENCY  = 2,
  parameter int MAX_PENDING = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  fft_sample_mem_responder_if.slave slave,
  output logic                      err_rw,
  output logic [15:0]               rd_count,
  output logic [15:0]               wr_count
);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              vld_reg [RD_LATENCY];
  logic [DATA_W-1:0] dat_reg [RD_LATENCY];
  logic [PEND_W-1:0] pending_reg;
  logic              err_rw_reg;
  logic [15:0]       rd_count_reg;
  logic [15:0]       wr_count_reg;
  logic              stall_inj;
  logic              rw_clash;
  logic              ret;
  logic              pend_full;
  logic              rd_acc;
  logic              wr_acc;

`ifdef STALL_INJECT_EN
  logic [15:0] lfsr_reg;

  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
  always_ff @(posedge clk) begin
    if (rst) lfsr_reg <= 16'hACE1;
    else     lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
  end
  assign stall_inj = lfsr_reg[0];
`else
  assign stall_inj = 1'b0;
`endif

  assign word_idx  = slave.address[ADDR_W+1:2];
  assign ret       = vld_reg[RD_LATENCY-1];
  assign rw_clash  = slave.read & slave.write;
  assign pend_full = (pending_reg == PEND_W'(MAX_PENDING));

  // A return in this cycle frees a slot, so a full pipeline can still take a read.
  assign slave.waitrequest = rst | stall_inj | rw_clash | (slave.read & pend_full & ~ret);

  // Writes win a read/write clash, so they ignore the clash term of waitrequest.
  assign wr_acc = slave.write & ~rst & ~stall_inj;
  assign rd_acc = slave.read & ~slave.waitrequest;

  assign slave.readdatavalid = vld_reg[RD_LATENCY-1];
  assign slave.readdata      = dat_reg[RD_LATENCY-1];
  assign err_rw   = err_rw_reg;
  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[word_idx] <= slave.writedata;
  end

  // Stage 0 is the registered RAM read; every stage holds its data when nothing moves in,
  // which keeps readdata stable between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_reg[i] <= 1'b0;
        dat_reg[i] <= '0;
      end
    end else begin
      vld_reg[0] <= rd_acc;
      if (rd_acc) dat_reg[0] <= mem[word_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        if (vld_reg[i-1]) dat_reg[i] <= dat_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      case ({rd_acc, ret})
        2'b10:   pending_reg <= pending_reg + PEND_W'(1);
        2'b01:   pending_reg <= pending_reg - PEND_W'(1);
        default: pending_reg <= pending_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_rw_reg   <= 1'b0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if (rw_clash) err_rw_reg <= 1'b1;
      if (rd_acc && rd_count_reg != 16'hFFFF) rd_count_reg <= rd_count_reg + 16'd1;
      if (wr_acc && wr_count_reg != 16'hFFFF) wr_count_reg <= wr_count_reg + 16'd1;
    end
  end
endmodule

// File: tb/tb_fft_sample_mem_responder.sv
// Bench for fft_sample_mem_responder: cycle model with an expected-return queue plus directed literal checks.
module tb_fft_sample_mem_responder;
  localparam int L    = 2;
  localparam int MAXP = 2;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_rw, err_rw2;
  logic [15:0] rd_count, wr_count, rd_count2, wr_count2;

  fft_sample_mem_responder_if #(.DATA_W(32)) bus ();
  fft_sample_mem_responder_if #(.DATA_W(32)) bus2 ();

  fft_sample_mem_responder #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(L), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst(rst), .slave(bus), .err_rw(err_rw), .rd_count(rd_count), .wr_count(wr_count)
  );

  fft_sample_mem_responder #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(3), .MAX_PENDING(1)) dut2 (
    .clk(clk), .rst(rst), .slave(bus2), .err_rw(err_rw2), .rd_count(rd_count2), .wr_count(wr_count2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model state
  pend_t       q[$];
  pend_t       p;
  logic [31:0] mmem [512];
  logic [31:0] last_d;
  int          m_rd, m_wr;
  bit          m_err;
  bit          model_on = 1'b0;
  bit          m_ret, m_ew;
  int          m_idx;
  logic [31:0] log_d[$];
  int          log_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.readdatavalid === 1'b1) begin
      log_d.push_back(bus.readdata);
      log_c.push_back(cyc);
    end
    m_ret = (q.size() > 0) && (q[0].due == cyc);
    m_ew  = rst || (bus.read && bus.write) || (bus.read && q.size() == MAXP && !m_ret);
    if (model_on) begin
      chk("waitrequest", bus.waitrequest, m_ew);
      chk("readdatavalid", bus.readdatavalid, m_ret);
      chk("readdata", bus.readdata, m_ret ? q[0].data : last_d);
      chk("rd_count", rd_count, m_rd);
      chk("wr_count", wr_count, m_wr);
      chk("err_rw", err_rw, m_err);
    end
    if (rst) begin
      q.delete();
      last_d   = '0;
      m_rd     = 0;
      m_wr     = 0;
      m_err    = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      m_idx = int'(bus.address[10:2]);
      if (m_ret) begin
        last_d = q[0].data;
        void'(q.pop_front());
      end
      if (bus.read && bus.write) m_err = 1'b1;
      if (bus.write) begin
        mmem[m_idx] = bus.writedata;
        if (m_wr < 65535) m_wr++;
      end
      if (bus.read && !m_ew) begin
        p.due  = cyc + L;
        p.data = mmem[m_idx];
        q.push_back(p);
        if (m_rd < 65535) m_rd++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit done;
    done = 1'b0;
    bus.read = r;
    bus.write = w;
    bus.address = a;
    bus.writedata = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!bus.waitrequest) begin
        done = 1'b1;
        if (r) last_acc = cyc;
      end
      step();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout actual=not_accepted expected=accepted addr=%h", a);
    end
    bus.read = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic wait_ret(input int n);
    for (int i = 0; i < 12 && log_d.size() <= n; i++) step();
  endtask

  task automatic expect_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    int n;
    n = log_d.size();
    xfer(1'b1, 1'b0, a, 32'h0);
    wait_ret(n);
    if (log_d.size() > n) chk(name, log_d[n], exp);
    else begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_return expected=%h", name, exp);
    end
  endtask

  initial begin
    int n, n0, first_acc, bad;
    bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0;
    bus2.read = 0; bus2.write = 0; bus2.address = 0; bus2.writedata = 0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // RD_LATENCY=3, MAX_PENDING=1 instance: one accept every 3 cycles under a held read
    bus2.read = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("p1_waitrequest", bus2.waitrequest, (k % 3) != 0);
      chk("p1_readdatavalid", bus2.readdatavalid, (k >= 3) && (k % 3 == 0));
      step();
    end
    bus2.read = 1'b0;
    step();
    step();
    chk("p1_rd_count", rd_count2, 32'd4);

    // Fill buffer with mem[i] = i
    for (int i = 0; i < 512; i++) xfer(1'b0, 1'b1, 32'(4 * i), 32'(i));
    chk("fill_wr_count", wr_count, 32'd512);

    // 512 back-to-back reads
    n0 = log_d.size();
    first_acc = -1;
    for (int i = 0; i < 512; i++) begin
      xfer(1'b1, 1'b0, 32'(4 * i), 32'h0);
      if (i == 0) first_acc = last_acc;
    end
    repeat (5) step();
    chk("burst_rd_count", rd_count, 32'd512);
    chk("burst_returns", 32'(log_d.size() - n0), 32'd512);
    if (log_d.size() >= n0 + 512) begin
      chk("burst_first_latency", 32'(log_c[n0] - first_acc), 32'd2);
      chk("burst_consecutive", 32'(log_c[n0 + 511] - log_c[n0]), 32'd511);
      bad = 0;
      for (int i = 0; i < 512; i++) if (log_d[n0 + i] !== 32'(i)) bad++;
      chk("burst_data_errors", 32'(bad), 32'd0);
    end

    // Read-after-write and address aliasing
    xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    expect_read("raw_deadbeef", 32'h10, 32'hDEADBEEF);
    xfer(1'b0, 1'b1, 32'h810, 32'h12345678);
    expect_read("alias_0x810", 32'h10, 32'h12345678);
    expect_read("low_bits_ignored", 32'h13, 32'h12345678);

    // Simultaneous read and write: write wins, read follows
    chk("err_rw_clear", err_rw, 32'd0);
    n = log_d.size();
    bus.read = 1'b1; bus.write = 1'b1; bus.address = 32'h20; bus.writedata = 32'h5;
    @(negedge clk);
    chk("rw_clash_wait", bus.waitrequest, 32'd1);
    step();
    bus.write = 1'b0;
    @(negedge clk);
    chk("rw_read_accept", bus.waitrequest, 32'd0);
    step();
    bus.read = 1'b0;
    wait_ret(n);
    if (log_d.size() > n) chk("rw_read_data", log_d[n], 32'h5);
    else begin
      checks++;
      errors++;
      $display("FAIL rw_read_data actual=no_return expected=00000005");
    end
    repeat (3) step();
    chk("err_rw_sticky", err_rw, 32'd1);

    // Reset with two reads in flight
    xfer(1'b1, 1'b0, 32'h0, 32'h0);
    xfer(1'b1, 1'b0, 32'h4, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_waitrequest", bus.waitrequest, 32'd1);
    step();
    rst = 1'b0;
    n = log_d.size();
    bus.read = 1'b1; bus.address = 32'h0;
    @(negedge clk);
    chk("post_rst_waitrequest", bus.waitrequest, 32'd0);
    chk("post_rst_rd_count", rd_count, 32'd0);
    chk("post_rst_wr_count", wr_count, 32'd0);
    chk("post_rst_err_rw", err_rw, 32'd0);
    first_acc = cyc;
    step();
    bus.read = 1'b0;
    repeat (6) step();
    chk("post_rst_returns", 32'(log_d.size() - n), 32'd1);
    if (log_d.size() > n) begin
      chk("post_rst_latency", 32'(log_c[n] - first_acc), 32'd2);
      chk("post_rst_mem0", log_d[n], 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
